// File: rtl/regfile_scoreboard.sv
// Register file: 2 combinational read ports, 1 write port, optional hardwired R0 and write bypass.
// Also tracks a pending-write bit per register for multi-cycle producers and drives stall flags.
module regfile_scoreboard #(
  parameter int DATA_W   = 24,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic [ADDR_W-1:0] RS,
  input  logic [ADDR_W-1:0] RT,
  input  logic [ADDR_W-1:0] RD,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  input  logic              MarkBusy,
  input  logic [ADDR_W-1:0] MarkAddr,
  output logic [DATA_W-1:0] ReadRS,
  output logic [DATA_W-1:0] ReadRT,
  output logic              StallRS,
  output logic              StallRT,
  output logic [ADDR_W:0]   PendCount
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  logic wr_ok, mark_ok, cnt_inc, cnt_dec;
  logic rs_zero, rt_zero, rs_fwd, rt_fwd;

  always_comb begin
    wr_ok   = RegWrite && !((ZERO_REG != 0) && (RD == '0));
    mark_ok = MarkBusy && !((ZERO_REG != 0) && (MarkAddr == '0));

    regs_d = regs_q;
    pend_d = pend_q;
    if (wr_ok) begin
      regs_d[RD] = WriteData;
      pend_d[RD] = 1'b0;
    end
    // Mark is applied last: a new producer outranks the write that retires the old one.
    if (mark_ok) begin
      pend_d[MarkAddr] = 1'b1;
    end

    cnt_inc = mark_ok && !pend_q[MarkAddr];
    cnt_dec = wr_ok && pend_q[RD] && !(mark_ok && (MarkAddr == RD));
    cnt_d   = cnt_q + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);
  end

  always_comb begin
    rs_zero = (ZERO_REG != 0) && (RS == '0);
    rt_zero = (ZERO_REG != 0) && (RT == '0);
    rs_fwd  = (BYPASS != 0) && wr_ok && (RD == RS);
    rt_fwd  = (BYPASS != 0) && wr_ok && (RD == RT);

    ReadRS = regs_q[RS];
    if (rs_zero)     ReadRS = '0;
    else if (rs_fwd) ReadRS = WriteData;

    ReadRT = regs_q[RT];
    if (rt_zero)     ReadRT = '0;
    else if (rt_fwd) ReadRT = WriteData;

    // A write landing this cycle satisfies the consumer through the bypass.
    StallRS = pend_q[RS] && !rs_zero && !((BYPASS != 0) && RegWrite && (RD == RS));
    StallRT = pend_q[RT] && !rt_zero && !((BYPASS != 0) && RegWrite && (RD == RT));

    PendCount = cnt_q;
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: bypass and no-bypass instances share stimulus,
// checked each cycle against a behavioural model plus directed literal expectations.
module tb_regfile_scoreboard;

  logic        Clock;
  logic        ResetN;
  logic [3:0]  RS, RT, RD, MarkAddr;
  logic [23:0] WriteData;
  logic        RegWrite, MarkBusy;

  logic [23:0] b_ReadRS, b_ReadRT, n_ReadRS, n_ReadRT;
  logic        b_StallRS, b_StallRT, n_StallRS, n_StallRT;
  logic [4:0]  b_PendCount, n_PendCount;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  regfile_scoreboard #(.DATA_W(24), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) u_byp (
    .Clock(Clock), .ResetN(ResetN), .RS(RS), .RT(RT), .RD(RD), .WriteData(WriteData),
    .RegWrite(RegWrite), .MarkBusy(MarkBusy), .MarkAddr(MarkAddr),
    .ReadRS(b_ReadRS), .ReadRT(b_ReadRT), .StallRS(b_StallRS), .StallRT(b_StallRT),
    .PendCount(b_PendCount)
  );

  regfile_scoreboard #(.DATA_W(24), .ADDR_W(4), .ZERO_REG(1), .BYPASS(0)) u_nob (
    .Clock(Clock), .ResetN(ResetN), .RS(RS), .RT(RT), .RD(RD), .WriteData(WriteData),
    .RegWrite(RegWrite), .MarkBusy(MarkBusy), .MarkAddr(MarkAddr),
    .ReadRS(n_ReadRS), .ReadRT(n_ReadRT), .StallRS(n_StallRS), .StallRT(n_StallRT),
    .PendCount(n_PendCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural register contents and set of pending registers.
  logic [23:0] m_reg  [16];
  bit          m_pend [16];

  always @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < 16; i++) begin
        m_reg[i]  = '0;
        m_pend[i] = 0;
      end
    end else begin
      if (RegWrite && RD != 0) begin
        m_reg[RD]  = WriteData;
        m_pend[RD] = 0;
      end
      if (MarkBusy && MarkAddr != 0) m_pend[MarkAddr] = 1;
    end
  end

  function automatic logic [23:0] m_read(input logic [3:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && RegWrite && RD == a) return WriteData;
    return m_reg[a];
  endfunction

  function automatic bit m_stall(input logic [3:0] a, input bit byp);
    return m_pend[a] && !(byp && RegWrite && RD == a);
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 16; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  always begin
    @(negedge Clock);
    #4;
    if (chk_en) begin
      chk("cmp_b_ReadRS", b_ReadRS, m_read(RS, 1));
      chk("cmp_b_ReadRT", b_ReadRT, m_read(RT, 1));
      chk("cmp_b_StallRS", b_StallRS, m_stall(RS, 1));
      chk("cmp_b_StallRT", b_StallRT, m_stall(RT, 1));
      chk("cmp_b_PendCount", b_PendCount, m_count());
      chk("cmp_n_ReadRS", n_ReadRS, m_read(RS, 0));
      chk("cmp_n_ReadRT", n_ReadRT, m_read(RT, 0));
      chk("cmp_n_StallRS", n_StallRS, m_stall(RS, 0));
      chk("cmp_n_StallRT", n_StallRT, m_stall(RT, 0));
      chk("cmp_n_PendCount", n_PendCount, m_count());
    end
  end

  task automatic drive(input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd,
                       input logic [23:0] wd, input logic we, input logic mb,
                       input logic [3:0] ma);
    @(negedge Clock);
    RS = rs; RT = rt; RD = rd; WriteData = wd; RegWrite = we; MarkBusy = mb; MarkAddr = ma;
  endtask

  initial begin
    ResetN = 1'b0;
    RS = 0; RT = 0; RD = 0; WriteData = 0; RegWrite = 0; MarkBusy = 0; MarkAddr = 0;
    #3;
    chk("rst_ReadRS", b_ReadRS, 24'h0);
    chk("rst_PendCount", b_PendCount, 5'd0);
    chk("rst_StallRS", b_StallRS, 1'b0);
    repeat (2) @(negedge Clock);
    ResetN = 1'b1;
    chk_en = 1;

    // Async reset clears stored data and pending state mid-cycle
    drive(5, 0, 5, 24'hABCDEF, 1, 1, 6);
    #3;
    chk("pre_b_bypass_R5", b_ReadRS, 24'hABCDEF);
    chk("pre_n_nobypass_R5", n_ReadRS, 24'h0);
    drive(5, 6, 0, 24'h0, 0, 0, 0);
    #3;
    chk("pre_R5", n_ReadRS, 24'hABCDEF);
    chk("pre_stall_R6", b_StallRT, 1'b1);
    chk("pre_pend", b_PendCount, 5'd1);
    ResetN = 1'b0;
    #1;
    chk("arst_ReadRS", b_ReadRS, 24'h0);
    chk("arst_n_ReadRS", n_ReadRS, 24'h0);
    chk("arst_PendCount", b_PendCount, 5'd0);
    chk("arst_StallRT", b_StallRT, 1'b0);
    @(negedge Clock);
    ResetN = 1'b1;

    // Write enable gating
    drive(0, 3, 3, 24'h123456, 0, 0, 0);
    #3;
    chk("we0_ReadRT", b_ReadRT, 24'h0);
    drive(0, 3, 3, 24'h123456, 1, 0, 0);
    #3;
    chk("we1_n_ReadRT_before", n_ReadRT, 24'h0);
    drive(0, 3, 0, 24'h0, 0, 0, 0);
    #3;
    chk("we1_ReadRT_after", n_ReadRT, 24'h123456);

    // Hardwired R0 ignores writes and marks
    drive(0, 0, 0, 24'hFFFFFF, 1, 1, 0);
    #3;
    chk("zero_ReadRS_same", b_ReadRS, 24'h0);
    drive(0, 0, 0, 24'h0, 0, 0, 0);
    #3;
    chk("zero_ReadRS", b_ReadRS, 24'h0);
    chk("zero_StallRS", b_StallRS, 1'b0);
    chk("zero_PendCount", b_PendCount, 5'd0);

    // Bypass versus registered visibility
    drive(0, 0, 7, 24'h000010, 1, 0, 0);
    drive(7, 7, 7, 24'h000020, 1, 0, 0);
    #3;
    chk("byp_b_ReadRS", b_ReadRS, 24'h000020);
    chk("byp_b_ReadRT", b_ReadRT, 24'h000020);
    chk("byp_n_ReadRS", n_ReadRS, 24'h000010);
    drive(7, 0, 0, 24'h0, 0, 0, 0);
    #3;
    chk("byp_n_after", n_ReadRS, 24'h000020);

    // Scoreboard mark then retire
    drive(0, 0, 0, 24'h0, 0, 1, 4);
    drive(4, 0, 0, 24'h0, 0, 0, 0);
    #3;
    chk("sb_StallRS", b_StallRS, 1'b1);
    chk("sb_PendCount", b_PendCount, 5'd1);
    drive(4, 0, 4, 24'h000055, 1, 0, 0);
    #3;
    chk("sb_b_StallRS_wr", b_StallRS, 1'b0);
    chk("sb_n_StallRS_wr", n_StallRS, 1'b1);
    chk("sb_b_ReadRS_wr", b_ReadRS, 24'h000055);
    drive(4, 0, 0, 24'h0, 0, 0, 0);
    #3;
    chk("sb_PendCount_after", b_PendCount, 5'd0);
    chk("sb_StallRS_after", n_StallRS, 1'b0);

    // Set and clear of the same register in one cycle: set wins
    drive(0, 0, 0, 24'h0, 0, 1, 9);
    drive(9, 0, 9, 24'h000099, 1, 1, 9);
    #3;
    chk("col_PendCount", b_PendCount, 5'd1);
    drive(9, 0, 0, 24'h0, 0, 0, 0);
    #3;
    chk("col_ReadRS", b_ReadRS, 24'h000099);
    chk("col_StallRS", b_StallRS, 1'b1);
    chk("col_PendCount_after", b_PendCount, 5'd1);

    // Fill every markable register; count saturates naturally at DEPTH-1
    for (int i = 1; i < 16; i++) drive(0, 0, 0, 24'h0, 0, 1, 4'(i));
    drive(0, 0, 0, 24'h0, 0, 1, 1);
    #3;
    chk("fill_PendCount", b_PendCount, 5'd15);
    drive(0, 0, 0, 24'h0, 0, 1, 0);
    #3;
    chk("fill_PendCount_remark", b_PendCount, 5'd15);
    drive(0, 0, 3, 24'h000333, 1, 0, 0);
    drive(3, 0, 0, 24'h0, 0, 0, 0);
    #3;
    chk("clr_PendCount", b_PendCount, 5'd14);
    chk("clr_StallRS", b_StallRS, 1'b0);
    // Set one register while retiring another: net zero
    drive(0, 0, 8, 24'h000888, 1, 1, 3);
    drive(3, 8, 0, 24'h0, 0, 0, 0);
    #3;
    chk("net0_PendCount", b_PendCount, 5'd14);
    chk("net0_StallRS", b_StallRS, 1'b1);
    chk("net0_StallRT", b_StallRT, 1'b0);
    chk("net0_ReadRT", b_ReadRT, 24'h000888);

    drive(0, 0, 0, 24'h0, 0, 0, 0);
    @(negedge Clock);
    #6;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
